// File: rtl/note_sequencer.sv
// note_sequencer: plays a melody stored in a small pattern RAM at a programmable tempo.
// Each entry is {rest, note[2:0], octave[1:0], accident, dur[3:0]}; dur=0 marks end-of-song.
module note_sequencer #(
  parameter int unsigned TICK_DIV   = 100000,
  parameter int unsigned GAP_CYCLES = 1000,
  parameter int unsigned DEPTH      = 32,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_play,
  input  logic          i_stop,
  input  logic          i_loop_en,
  input  logic [1:0]    i_tempo_sel,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [10:0]   i_wr_data,
  output logic [2:0]    o_note,
  output logic [1:0]    o_octave,
  output logic          o_accident,
  output logic          o_gate,
  output logic          o_busy,
  output logic [AW-1:0] o_step_idx,
  output logic          o_done
);

  localparam int unsigned   CW         = $clog2(TICK_DIV + 1);
  localparam int unsigned   GW         = $clog2(GAP_CYCLES + 2);
  localparam logic [CW-1:0] TICK_DIV_W = CW'(TICK_DIV);
  localparam logic [AW-1:0] LAST_IDX   = AW'(DEPTH - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StHold, StGap} state_e;

  state_e        r_state;
  logic [10:0]   r_mem [DEPTH];
  logic [10:0]   r_rd_data;
  logic [2:0]    r_note;
  logic [1:0]    r_octave;
  logic          r_accident;
  logic          r_gate;
  logic          r_done;
  logic [AW-1:0] r_step_idx;
  logic [3:0]    r_remaining;
  logic [CW-1:0] r_tick_cnt;
  logic [CW-1:0] r_period;
  logic [GW-1:0] r_gap_cnt;

  logic          w_rest;
  logic [2:0]    w_note;
  logic [1:0]    w_octave;
  logic          w_accident;
  logic [3:0]    w_dur;
  logic [CW-1:0] w_period;
  logic          w_tick;
  logic          w_gap_last;

  assign w_rest     = r_rd_data[10];
  assign w_note     = r_rd_data[9:7];
  assign w_octave   = r_rd_data[6:5];
  assign w_accident = r_rd_data[4];
  assign w_dur      = r_rd_data[3:0];

  // Period is sampled only on HOLD entry and at each wrap, so tempo changes land on a wrap.
  assign w_period   = TICK_DIV_W >> i_tempo_sel;
  assign w_tick     = (32'(r_tick_cnt) + 32'd1) >= 32'(r_period);
  assign w_gap_last = (32'(r_gap_cnt) + 32'd1) >= GAP_CYCLES;

  // Pattern RAM: writes only while idle, registered read of the current step address.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && (r_state == StIdle)) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    r_rd_data <= r_mem[r_step_idx];
  end

  // Sequencer FSM with registered outputs; reset beats stop, stop beats everything else.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_note      <= '0;
      r_octave    <= '0;
      r_accident  <= 1'b0;
      r_gate      <= 1'b0;
      r_done      <= 1'b0;
      r_step_idx  <= '0;
      r_remaining <= '0;
      r_tick_cnt  <= '0;
      r_period    <= '0;
      r_gap_cnt   <= '0;
    end else if (i_stop) begin
      r_state <= StIdle;
      r_gate  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_play) begin
            r_step_idx <= '0;
            r_state    <= StFetch;
          end
        end
        StFetch: begin
          r_state <= StDecode;
        end
        StDecode: begin
          if (w_dur != 4'd0) begin
            r_note      <= w_note;
            r_octave    <= w_octave;
            r_accident  <= w_accident;
            r_gate      <= ~w_rest;
            r_remaining <= w_dur;
            r_tick_cnt  <= '0;
            r_period    <= w_period;
            r_state     <= StHold;
          end else if (i_loop_en && (r_step_idx != '0)) begin
            r_step_idx <= '0;
            r_state    <= StFetch;
          end else begin
            r_done  <= 1'b1;
            r_state <= StIdle;
          end
        end
        StHold: begin
          if (w_tick) begin
            r_tick_cnt  <= '0;
            r_period    <= w_period;
            r_remaining <= r_remaining - 4'd1;
            if (r_remaining == 4'd1) begin
              r_gate    <= 1'b0;
              r_gap_cnt <= '0;
              r_state   <= StGap;
            end
          end else begin
            r_tick_cnt <= r_tick_cnt + CW'(1);
          end
        end
        StGap: begin
          if (w_gap_last) begin
            // Running off the last entry behaves like an end-of-song marker.
            if (r_step_idx == LAST_IDX) begin
              if (i_loop_en && (r_step_idx != '0)) begin
                r_step_idx <= '0;
                r_state    <= StFetch;
              end else begin
                r_done  <= 1'b1;
                r_state <= StIdle;
              end
            end else begin
              r_step_idx <= r_step_idx + AW'(1);
              r_state    <= StFetch;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_note     = r_note;
  assign o_octave   = r_octave;
  assign o_accident = r_accident;
  assign o_gate     = r_gate;
  assign o_busy     = (r_state != StIdle);
  assign o_step_idx = r_step_idx;
  assign o_done     = r_done;

endmodule
